// File: rtl/down_counter_pkg.sv
// Shared constants for the ripple-borrow down counter.
package down_counter_pkg;

    // Default counter width in bits.
    localparam int unsigned COUNT_W_DEFAULT = 3;

    // Largest count value at the default width; a wrap from zero lands here.
    localparam int unsigned COUNT_MAX = (1 << COUNT_W_DEFAULT) - 1;

    // Value forced into the counter by reset.
    localparam int unsigned RESET_VAL = 0;

endpackage : down_counter_pkg

// File: rtl/down_counter_stage.sv
// One bit of the down counter: synchronous reset, parallel load and toggle on borrow-in.
module down_counter_stage #(
    parameter logic RST_BIT = 1'b0
) (
    input  logic Clk,
    input  logic Rst,
    input  logic load,
    input  logic load_bit,
    input  logic borrow_in,
    output logic q,
    output logic borrow_out_c
);

    // Bit register: reset beats load, load beats toggle.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            q <= RST_BIT;
        end else if (load) begin
            q <= load_bit;
        end else if (borrow_in) begin
            q <= ~q;
        end
    end

    // A borrow passes upward only when this bit is already zero.
    assign borrow_out_c = borrow_in & ~q;

endmodule : down_counter_stage

// File: rtl/down_counter.sv
// Loadable down counter built from a chain of ripple-borrow stages, with a sticky underflow flag.
module down_counter
    import down_counter_pkg::*;
#(
    parameter int unsigned COUNT_W = COUNT_W_DEFAULT
) (
    input  logic               Clk,
    input  logic               Rst,
    input  logic               En,
    input  logic               Load,
    input  logic [COUNT_W-1:0] LoadVal,
    output logic [COUNT_W-1:0] Count,
    output logic               Borrow2,
    output logic               Zero,
    output logic               Underflow
);

    localparam logic [COUNT_W-1:0] RST_VEC = COUNT_W'(RESET_VAL);

    // borrow[i] is the borrow into stage i; the last entry leaves the MSB.
    logic [COUNT_W:0] borrow;

    assign borrow[0] = En;

    // One stage per counter bit, chained LSB to MSB.
    for (genvar i = 0; i < COUNT_W; i++) begin : g_stage
        down_counter_stage #(
            .RST_BIT (RST_VEC[i])
        ) u_stage (
            .Clk          (Clk),
            .Rst          (Rst),
            .load         (Load),
            .load_bit     (LoadVal[i]),
            .borrow_in    (borrow[i]),
            .q            (Count[i]),
            .borrow_out_c (borrow[i+1])
        );
    end

    // Borrow out of the MSB means the next enabled edge wraps past zero.
    assign Borrow2 = borrow[COUNT_W];

    // Zero decode straight off the count register.
    assign Zero = (Count == '0);

    // Sticky underflow: set on a wrap, cleared only by reset or load.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            Underflow <= 1'b0;
        end else if (Load) begin
            Underflow <= 1'b0;
        end else if (Borrow2) begin
            Underflow <= 1'b1;
        end
    end

endmodule : down_counter
